// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, fetch-queue entry type and reset PC shared by the front end.
package riscv_pkg;

    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [6:0]  OPC_JALR     = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir1;
        logic [31:0] ir2;
        logic        vld2;
    } fq_entry_t;

    function automatic logic is_ctrl(input logic [6:0] opc);
        return opc == OPC_JAL || opc == OPC_JALR || opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry show-ahead FIFO of fetched pairs; an empty queue passes a push straight to dout.
import riscv_pkg::*;

module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fq_entry_t               din,
    output fq_entry_t               dout,
    output logic                    vld,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          empty, bypass, wr, rd;

    assign empty  = count == '0;
    // a pair popped in the same cycle it arrives at an empty queue never occupies a slot
    assign bypass = empty & push & pop;
    assign wr     = push & !bypass;
    assign rd     = pop & !empty;
    assign vld    = !empty | push;
    assign dout   = !empty ? mem[rp] : push ? din : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(wr);
            rp    <= rp + PW'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !flush) mem[wp] <= din;
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: aligned-pair instruction fetch with credit-based queueing and epoch-tagged redirects.
// Define PREDECODE_CUT_EN to drop slot 2 behind a slot-1 JAL/JALR/BRANCH.
import riscv_pkg::*;

module fetch_controller #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          AW       = 13,
    parameter int          FQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_vld,
    input  logic [31:0]   redirect_pc,
    output logic [AW-1:0] imem_addr1,
    output logic [AW-1:0] imem_addr2,
    input  logic [31:0]   imem_ir1,
    input  logic [31:0]   imem_ir2,
    output logic          fq_vld,
    input  logic          fq_rdy,
    output logic [31:0]   fq_pc,
    output logic [31:0]   fq_ir1,
    output logic [31:0]   fq_ir2,
    output logic          fq_vld2
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]   pc, req_pc;
    logic          epoch, req_epoch, inflight;
    logic          issue, push, pop, head_vld;
    logic [CW-1:0] count;
    fq_entry_t     din, head;

    assign imem_addr1 = pc[AW+1:2];
    assign imem_addr2 = imem_addr1 + AW'(1);

    // the in-flight read already holds a credit, so a response always has a free slot
    assign issue = !redirect_vld && (count + CW'(inflight)) < CW'(FQ_DEPTH);
    assign push  = inflight && req_epoch == epoch && !redirect_vld;
    assign pop   = head_vld && fq_rdy && !redirect_vld;

`ifdef PREDECODE_CUT_EN
    assign din = '{pc: req_pc, ir1: imem_ir1, ir2: imem_ir2, vld2: !is_ctrl(imem_ir1[6:0])};
`else
    assign din = '{pc: req_pc, ir1: imem_ir1, ir2: imem_ir2, vld2: 1'b1};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            req_pc    <= '0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_vld) begin
                pc    <= redirect_pc & ~32'h3;
                epoch <= !epoch;
            end else if (issue) begin
                pc        <= pc + 32'd8;
                req_pc    <= pc;
                req_epoch <= epoch;
            end
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_vld),
        .din   (din),
        .dout  (head),
        .vld   (head_vld),
        .count (count)
    );

    assign fq_vld  = head_vld;
    assign fq_pc   = head.pc;
    assign fq_ir1  = head.ir1;
    assign fq_ir2  = head.ir2;
    assign fq_vld2 = head_vld & head.vld2;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized redirect/backpressure run against a PC-stream model.
module tb_fetch_controller;

    localparam int AW = 13;

    logic          clk = 1'b0, rst_n = 1'b0, redirect_vld = 1'b0, fq_rdy = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [AW-1:0] imem_addr1, imem_addr2;
    logic [31:0]   imem_ir1 = '0, imem_ir2 = '0, fq_pc, fq_ir1, fq_ir2;
    logic          fq_vld, fq_vld2;
    logic [31:0]   mem [1 << AW];
    int            tests = 0, fails = 0;

    fetch_controller #(.RESET_PC(32'h0), .AW(AW), .FQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .imem_addr1(imem_addr1), .imem_addr2(imem_addr2), .imem_ir1(imem_ir1), .imem_ir2(imem_ir2),
        .fq_vld(fq_vld), .fq_rdy(fq_rdy), .fq_pc(fq_pc), .fq_ir1(fq_ir1), .fq_ir2(fq_ir2),
        .fq_vld2(fq_vld2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_ir1 <= mem[imem_addr1];
        imem_ir2 <= mem[imem_addr2];
    end

    function automatic logic [31:0] w1(input logic [31:0] p);
        logic [AW-1:0] a;
        a = p[AW+1:2];
        return mem[a];
    endfunction

    function automatic logic [31:0] w2(input logic [31:0] p);
        logic [AW-1:0] a;
        a = p[AW+1:2] + 1'b1;
        return mem[a];
    endfunction

    function automatic logic want_vld2(input logic [31:0] w);
`ifdef PREDECODE_CUT_EN
        return !(w[6:0] == 7'h6F || w[6:0] == 7'h67 || w[6:0] == 7'h63);
`else
        return 1'b1;
`endif
    endfunction

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        fq_rdy = r;
        redirect_vld = rv;
        redirect_pc = rp;
        #1;
    endtask

    task automatic do_reset(input logic r);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_vld = 1'b0;
        fq_rdy = r;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({fq_vld, fq_vld2, fq_pc, fq_ir1, fq_ir2} !== '0 || imem_addr1 !== 13'h0 || imem_addr2 !== 13'h1) begin
            fails++;
            $display("FAIL reset: vld=%b vld2=%b pc=%h ir1=%h ir2=%h a1=%h a2=%h, want all 0 and a2=1",
                     fq_vld, fq_vld2, fq_pc, fq_ir1, fq_ir2, imem_addr1, imem_addr2);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        tests++;
        if (fq_vld !== 1'b0) begin
            fails++;
            $display("FAIL stream_first: fq_vld=%b in release cycle, want 0", fq_vld);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, '0);
            tests++;
            if (fq_vld !== 1'b1 || fq_vld2 !== 1'b1 || fq_pc !== 32'(8*k) || fq_ir1 !== 32'(2*k) || fq_ir2 !== 32'(2*k+1)) begin
                fails++;
                $display("FAIL stream[%0d]: vld=%b vld2=%b pc=%h ir=%h,%h want 1 1 pc=%h ir=%h,%h",
                         k, fq_vld, fq_vld2, fq_pc, fq_ir1, fq_ir2, 8*k, 2*k, 2*k+1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (10) cyc(1'b0, 1'b0, '0);
        tests++;
        if (fq_vld !== 1'b1 || fq_pc !== 32'h0 || imem_addr1 !== 13'h8) begin
            fails++;
            $display("FAIL bp_hold: vld=%b pc=%h addr1=%h, want 1 0 8", fq_vld, fq_pc, imem_addr1);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, '0);
            tests++;
            if (fq_vld !== 1'b1 || fq_pc !== 32'(8*k) || fq_ir1 !== 32'(2*k) || fq_ir2 !== 32'(2*k+1)) begin
                fails++;
                $display("FAIL bp_drain[%0d]: vld=%b pc=%h ir1=%h, want 1 pc=%h ir1=%h", k, fq_vld, fq_pc, fq_ir1, 8*k, 2*k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h103);
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (fq_vld !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush: fq_vld=%b pc=%h, want 0", fq_vld, fq_pc);
        end
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (fq_vld !== 1'b1 || fq_pc !== 32'h100 || fq_ir1 !== 32'h40 || fq_ir2 !== 32'h41) begin
            fails++;
            $display("FAIL redir_target: vld=%b pc=%h ir=%h,%h want 1 pc=100 ir=40,41", fq_vld, fq_pc, fq_ir1, fq_ir2);
        end
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (fq_vld !== 1'b1 || fq_pc !== 32'h108 || fq_ir1 !== 32'h42) begin
            fails++;
            $display("FAIL redir_next: vld=%b pc=%h ir1=%h want 1 pc=108 ir1=42", fq_vld, fq_pc, fq_ir1);
        end
    endtask

    task automatic test_back_to_back();
        logic seen200;
        seen200 = 1'b0;
        cyc(1'b1, 1'b1, 32'h200);
        cyc(1'b1, 1'b1, 32'h300);
        seen200 |= fq_vld && fq_pc[31:8] == 24'h2;
        cyc(1'b1, 1'b0, '0);
        seen200 |= fq_vld && fq_pc[31:8] == 24'h2;
        tests++;
        if (fq_vld !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: fq_vld=%b pc=%h, want 0", fq_vld, fq_pc);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, '0);
            seen200 |= fq_vld && fq_pc[31:8] == 24'h2;
            tests++;
            if (fq_vld !== 1'b1 || fq_pc !== 32'(32'h300 + 8*k) || fq_ir1 !== 32'(32'hC0 + 2*k)) begin
                fails++;
                $display("FAIL b2b_pair[%0d]: vld=%b pc=%h ir1=%h want 1 pc=%h ir1=%h", k, fq_vld, fq_pc, fq_ir1, 32'h300 + 8*k, 32'hC0 + 2*k);
            end
        end
        tests++;
        if (seen200 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stale: a 0x2xx entry was visible=%b, want 0", seen200);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b1, 1'b1, 32'h7FF8);
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (imem_addr1 !== 13'h1FFE || imem_addr2 !== 13'h1FFF) begin
            fails++;
            $display("FAIL wrap_last: a1=%h a2=%h want 1ffe 1fff", imem_addr1, imem_addr2);
        end
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (imem_addr1 !== 13'h0 || imem_addr2 !== 13'h1 || fq_pc !== 32'h7FF8 || fq_ir1 !== 32'h1FFE || fq_ir2 !== 32'h1FFF) begin
            fails++;
            $display("FAIL wrap_next: a1=%h a2=%h pc=%h ir=%h,%h want 0 1 7ff8 1ffe,1fff", imem_addr1, imem_addr2, fq_pc, fq_ir1, fq_ir2);
        end
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (fq_vld !== 1'b1 || fq_pc !== 32'h8000 || fq_ir1 !== 32'h0 || fq_ir2 !== 32'h1) begin
            fails++;
            $display("FAIL wrap_pc: vld=%b pc=%h ir=%h,%h want 1 8000 0,1", fq_vld, fq_pc, fq_ir1, fq_ir2);
        end
        cyc(1'b1, 1'b1, 32'h7FFE);
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (imem_addr1 !== 13'h1FFF || imem_addr2 !== 13'h0) begin
            fails++;
            $display("FAIL wrap_addr2: a1=%h a2=%h want 1fff 0", imem_addr1, imem_addr2);
        end
        cyc(1'b1, 1'b0, '0);
        tests++;
        if (fq_pc !== 32'h7FFC || fq_ir1 !== 32'h1FFF || fq_ir2 !== 32'h0) begin
            fails++;
            $display("FAIL wrap_pair: pc=%h ir=%h,%h want 7ffc 1fff,0", fq_pc, fq_ir1, fq_ir2);
        end
    endtask

    task automatic test_predecode();
        logic [3:0] want;
`ifdef PREDECODE_CUT_EN
        want = 4'b0010;
`else
        want = 4'b1111;
`endif
        mem[13'h100] = 32'h0000_006F;
        mem[13'h102] = 32'h0000_0013;
        mem[13'h103] = 32'h0000_006F;
        mem[13'h104] = 32'h0000_8067;
        mem[13'h106] = 32'h00B5_0463;
        cyc(1'b1, 1'b1, 32'h400);
        cyc(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, '0);
            tests++;
            if (fq_vld !== 1'b1 || fq_pc !== 32'(32'h400 + 8*k) || fq_vld2 !== want[k]) begin
                fails++;
                $display("FAIL predecode[%0d]: vld=%b pc=%h vld2=%b want 1 pc=%h vld2=%b", k, fq_vld, fq_pc, fq_vld2, 32'h400 + 8*k, want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (fq_vld !== 1'b0 || fq_vld2 !== 1'b0 || fq_pc !== 32'h0 || imem_addr1 !== 13'h0) begin
            fails++;
            $display("FAIL reset_mid: vld=%b vld2=%b pc=%h a1=%h want 0 0 0 0", fq_vld, fq_vld2, fq_pc, imem_addr1);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, rp;
        logic        r, rv;
        int          low;
        do_reset(1'b1);
        exp_pc = 32'h0;
        low = 0;
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 9) < 7;
            rv = $urandom_range(0, 19) == 0;
            rp = $urandom;
            cyc(r, rv, rp);
            if (rv) begin
                exp_pc = rp & ~32'h3;
                low = 0;
            end else if (!fq_vld) begin
                low++;
                tests++;
                if (low > 2) begin
                    fails++;
                    $display("FAIL rand_stall[%0d]: fq_vld low for %0d cycles, want at most 2", i, low);
                end
            end else begin
                low = 0;
                if (r) begin
                    tests++;
                    if (fq_pc !== exp_pc || fq_ir1 !== w1(exp_pc) || fq_ir2 !== w2(exp_pc) || fq_vld2 !== want_vld2(w1(exp_pc))) begin
                        fails++;
                        $display("FAIL rand_pair[%0d]: pc=%h ir=%h,%h vld2=%b want pc=%h ir=%h,%h vld2=%b",
                                 i, fq_pc, fq_ir1, fq_ir2, fq_vld2, exp_pc, w1(exp_pc), w2(exp_pc), want_vld2(w1(exp_pc)));
                    end
                    exp_pc += 32'd8;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_predecode();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
